// File: rtl/tc_pl_gc_merge_if.sv
// tc_pl_gc_merge_if: merged-word valid/ready stream.
//   Gc_merge_data  : FIFO head word, valid while Gc_mereg_datv is high
//   Gc_mereg_datv  : head word valid (FIFO non-empty)
//   Gc_mereg_datr  : consumer ready; a word is taken when datv & datr
// master = producer (tc_pl_gc_merge), slave = consumer.
interface tc_pl_gc_merge_if #(
   parameter int unsigned ADC0_1 = 56
);
   logic [ADC0_1-1:0] Gc_merge_data;
   logic              Gc_mereg_datv;
   logic              Gc_mereg_datr;

   modport master (output Gc_merge_data, output Gc_mereg_datv, input Gc_mereg_datr);
   modport slave  (input Gc_merge_data, input Gc_mereg_datv, output Gc_mereg_datr);
endinterface

// File: rtl/tc_pl_gc_merge.sv
// tc_pl_gc_merge: on a capture trigger, merges cap_points sets of four ADC
// samples into {ch3,ch2,ch1,ch0} words, buffers them in a 2^FIFO_AW deep
// first-word-fall-through FIFO and streams them out over gc_out.
// Ports:
//   clk125, rst          : clock, synchronous active-high reset
//   adc_ch0..3, adc_datv : channel samples and their strobe
//   Gc_cap_trig          : capture request, accepted only while Gc_capr_rdy
//   cap_points           : sample sets per capture, latched on acceptance
//   Gc_capr_rdy          : idle, ready for a trigger
//   gc_out               : merged-word stream (master)
//   merge_ovf            : sticky, a word was dropped on a full FIFO
//   merge_busy           : capture or drain in progress
// Build option: GC_MERGE_TESTPAT_EN replaces ADC samples by a ramp cnt+k.
module tc_pl_gc_merge #(
   parameter int unsigned ADC_W   = 14,
   parameter int unsigned ADC0_1  = 56,
   parameter int unsigned CAP0_6  = 14,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic                clk125,
   input  logic                rst,
   input  logic [ADC_W-1:0]    adc_ch0,
   input  logic [ADC_W-1:0]    adc_ch1,
   input  logic [ADC_W-1:0]    adc_ch2,
   input  logic [ADC_W-1:0]    adc_ch3,
   input  logic                adc_datv,
   input  logic                Gc_cap_trig,
   input  logic [CAP0_6-1:0]   cap_points,
   output logic                Gc_capr_rdy,
   tc_pl_gc_merge_if.master    gc_out,
   output logic                merge_ovf,
   output logic                merge_busy
);
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned OCC_W = FIFO_AW + 1;

   typedef enum logic [1:0] {IDLE, CAPT, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [CAP0_6-1:0]   cnt_q, cnt_d, pts_q, pts_d;
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]    occ_q, occ_d, occ_after_pop;
   logic [ADC0_1-1:0]   mem [DEPTH];
   logic [ADC0_1-1:0]   word_c, head_d, data_q;
   logic                datv_q, ovf_d;
   logic                pop, push_req, push_ok;

   // Sample word source
`ifdef GC_MERGE_TESTPAT_EN
   assign word_c = {ADC_W'(cnt_q + CAP0_6'(3)), ADC_W'(cnt_q + CAP0_6'(2)),
                    ADC_W'(cnt_q + CAP0_6'(1)), ADC_W'(cnt_q)};
`else
   assign word_c = {adc_ch3, adc_ch2, adc_ch1, adc_ch0};
`endif

   assign pop = datv_q & gc_out.Gc_mereg_datr;

   // Next state, capture counter, FIFO bookkeeping
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pts_d    = pts_q;
      ovf_d    = merge_ovf;
      push_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (Gc_cap_trig) begin
               pts_d   = cap_points;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = CAPT;
            end
         end
         CAPT: begin
            // exact compare also covers a zero-length capture
            if (cnt_q == pts_q) begin
               state_d = DRAIN;
            end else if (adc_datv) begin
               push_req = 1'b1;
               cnt_d    = cnt_q + CAP0_6'(1);
               if (cnt_d == pts_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (occ_after_pop == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // a pop in the same cycle frees the slot for a push into a full FIFO
      push_ok = push_req && ((occ_q != OCC_W'(DEPTH)) || pop);
      if (push_req && !push_ok) ovf_d = 1'b1;

      occ_after_pop = occ_q - OCC_W'(pop);
      occ_d         = occ_after_pop + OCC_W'(push_ok);
      rd_ptr_d      = rd_ptr_q + FIFO_AW'(pop);
      wr_ptr_d      = wr_ptr_q + FIFO_AW'(push_ok);

      // registered FWFT head: bypass the pushed word when it becomes the head
      if (occ_d == '0)               head_d = '0;
      else if (occ_after_pop == '0)  head_d = word_c;
      else                           head_d = mem[rd_ptr_d];
   end

   // State register
   always_ff @(posedge clk125) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Control, pointer and output registers
   always_ff @(posedge clk125) begin
      if (rst) begin
         cnt_q       <= '0;
         pts_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         merge_ovf   <= 1'b0;
         datv_q      <= 1'b0;
         data_q      <= '0;
         Gc_capr_rdy <= 1'b1;
         merge_busy  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pts_q       <= pts_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         merge_ovf   <= ovf_d;
         datv_q      <= (occ_d != '0);
         data_q      <= head_d;
         Gc_capr_rdy <= (state_d == IDLE);
         merge_busy  <= (state_d != IDLE);
      end
   end

   // FIFO storage, no reset needed: occupancy gates every read
   always_ff @(posedge clk125) begin
      if (push_ok) mem[wr_ptr_q] <= word_c;
   end

   assign gc_out.Gc_merge_data = data_q;
   assign gc_out.Gc_mereg_datv = datv_q;
endmodule

// File: tb/tb_tc_pl_gc_merge.sv
// tb_tc_pl_gc_merge: table-driven captures, hand-written corner sequences and
// randomized traffic, all checked every cycle against a queue-based model.
module tb_tc_pl_gc_merge;
   localparam int unsigned ADC_W  = 14;
   localparam int unsigned ADC0_1 = 56;
   localparam int unsigned CAP0_6 = 14;

   typedef logic [ADC0_1-1:0] word_t;
   typedef enum {M_IDLE, M_CAPT, M_DRAIN} mphase_t;
   typedef struct {
      int pts;
      int hold;       // cycles after the trigger with the consumer stalled
      int exp_words;
      bit exp_ovf;
      int exp_low;    // cycles Gc_capr_rdy stays low
   } vec_t;

   logic               clk125 = 1'b0;
   logic               rst;
   logic [ADC_W-1:0]   adc_ch0, adc_ch1, adc_ch2, adc_ch3;
   logic               adc_datv, Gc_cap_trig;
   logic [CAP0_6-1:0]  cap_points;
   logic               Gc_capr_rdy, merge_ovf, merge_busy;

   tc_pl_gc_merge_if #(.ADC0_1(ADC0_1)) gc_if ();

   tc_pl_gc_merge dut (
      .clk125      (clk125),
      .rst         (rst),
      .adc_ch0     (adc_ch0),
      .adc_ch1     (adc_ch1),
      .adc_ch2     (adc_ch2),
      .adc_ch3     (adc_ch3),
      .adc_datv    (adc_datv),
      .Gc_cap_trig (Gc_cap_trig),
      .cap_points  (cap_points),
      .Gc_capr_rdy (Gc_capr_rdy),
      .gc_out      (gc_if),
      .merge_ovf   (merge_ovf),
      .merge_busy  (merge_busy)
   );

   always #4 clk125 = ~clk125;

   word_t   m_q[$];
   word_t   got[$];
   mphase_t m_phase = M_IDLE;
   int      m_left, m_sidx;
   bit      m_ovf;
   int      n_chk = 0, n_pass = 0;
   int      rdy_low;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic word_t exp_word(input int i);
`ifdef GC_MERGE_TESTPAT_EN
      return {14'(i + 3), 14'(i + 2), 14'(i + 1), 14'(i)};
`else
      return {14'(768 + i), 14'(512 + i), 14'(256 + i), 14'(i)};
`endif
   endfunction

   task automatic set_ch(input int idx);
      adc_ch0 = 14'(idx);
      adc_ch1 = 14'(256 + idx);
      adc_ch2 = 14'(512 + idx);
      adc_ch3 = 14'(768 + idx);
   endtask

   // Reference: capture = take the next pts strobed sample sets, then wait
   // for the queue to empty; a full queue drops unless a word leaves too.
   task automatic model_step();
      bit    pop;
      int    occ0;
      word_t w;
      if (rst) begin
         m_q.delete();
         m_phase = M_IDLE;
         m_ovf   = 1'b0;
         return;
      end
      occ0 = m_q.size();
      pop  = (occ0 > 0) && gc_if.Gc_mereg_datr;
      if (pop) void'(m_q.pop_front());
      case (m_phase)
         M_IDLE: if (Gc_cap_trig) begin
            m_phase = M_CAPT;
            m_left  = int'(cap_points);
            m_sidx  = 0;
            m_ovf   = 1'b0;
         end
         M_CAPT: if (m_left == 0) m_phase = M_DRAIN;
                 else if (adc_datv) begin
`ifdef GC_MERGE_TESTPAT_EN
            w = {14'(m_sidx + 3), 14'(m_sidx + 2), 14'(m_sidx + 1), 14'(m_sidx)};
`else
            w = {adc_ch3, adc_ch2, adc_ch1, adc_ch0};
`endif
            if (occ0 < 16 || pop) m_q.push_back(w);
            else m_ovf = 1'b1;
            m_sidx++;
            m_left--;
            if (m_left == 0) m_phase = M_DRAIN;
         end
         default: if (m_q.size() == 0) m_phase = M_IDLE;
      endcase
   endtask

   task automatic check_outputs();
      word_t head;
      head = '0;
      if (m_q.size() != 0) head = m_q[0];
      chk("capr_rdy", 64'(Gc_capr_rdy), 64'(m_phase == M_IDLE));
      chk("merge_busy", 64'(merge_busy), 64'(m_phase != M_IDLE));
      chk("datv", 64'(gc_if.Gc_mereg_datv), 64'(m_q.size() != 0));
      chk("data", 64'(gc_if.Gc_merge_data), 64'(head));
      chk("merge_ovf", 64'(merge_ovf), 64'(m_ovf));
   endtask

   // Inputs are set before the call; outputs are checked 1 ns after the edge.
   task automatic tick();
      if (!rst && gc_if.Gc_mereg_datv && gc_if.Gc_mereg_datr)
         got.push_back(gc_if.Gc_merge_data);
      model_step();
      @(posedge clk125);
      #1;
      check_outputs();
      if (!Gc_capr_rdy) rdy_low++;
   endtask

   task automatic run_capture(input int pts, input int hold);
      got.delete();
      rdy_low     = 0;
      cap_points  = CAP0_6'(pts);
      Gc_cap_trig = 1'b1;
      adc_datv    = 1'b0;
      gc_if.Gc_mereg_datr = (hold == 0);
      tick();
      Gc_cap_trig = 1'b0;
      for (int c = 0; c < 400; c++) begin
         adc_datv = 1'b1;
         set_ch(c);
         gc_if.Gc_mereg_datr = (c >= hold);
         tick();
         if (m_phase == M_IDLE) break;
      end
      adc_datv = 1'b0;
      chk("capture_done", 64'(Gc_capr_rdy), 64'(1));
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{pts: 4,  hold: 0,  exp_words: 4,  exp_ovf: 1'b0, exp_low: 5};
      tbl[1] = '{pts: 1,  hold: 0,  exp_words: 1,  exp_ovf: 1'b0, exp_low: 2};
      tbl[2] = '{pts: 0,  hold: 0,  exp_words: 0,  exp_ovf: 1'b0, exp_low: 2};
      tbl[3] = '{pts: 16, hold: 20, exp_words: 16, exp_ovf: 1'b0, exp_low: 36};
      tbl[4] = '{pts: 17, hold: 16, exp_words: 17, exp_ovf: 1'b0, exp_low: 33};
      tbl[5] = '{pts: 20, hold: 30, exp_words: 16, exp_ovf: 1'b1, exp_low: 46};

      rst = 1'b1;
      adc_datv = 1'b0;
      Gc_cap_trig = 1'b0;
      cap_points = '0;
      set_ch(0);
      gc_if.Gc_mereg_datr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_rdy", 64'(Gc_capr_rdy), 64'(1));
      chk("rst_datv", 64'(gc_if.Gc_mereg_datv), 64'(0));
      chk("rst_data", 64'(gc_if.Gc_merge_data), 64'(0));
      chk("rst_ovf", 64'(merge_ovf), 64'(0));
      chk("rst_busy", 64'(merge_busy), 64'(0));
      tick();

      // Table-driven captures
      for (int v = 0; v < 6; v++) begin
         run_capture(tbl[v].pts, tbl[v].hold);
         chk("words_n", 64'(got.size()), 64'(tbl[v].exp_words));
         for (int i = 0; i < got.size() && i < tbl[v].exp_words; i++)
            chk("word", 64'(got[i]), 64'(exp_word(i)));
         chk("ovf_end", 64'(merge_ovf), 64'(tbl[v].exp_ovf));
         chk("rdy_low_cycles", 64'(rdy_low), 64'(tbl[v].exp_low));
         tick();
      end

      // Trigger during CAPT must be ignored
      got.delete();
      cap_points = CAP0_6'(6);
      Gc_cap_trig = 1'b1;
      gc_if.Gc_mereg_datr = 1'b1;
      tick();
      for (int c = 0; c < 100; c++) begin
         Gc_cap_trig = (c == 2);
         cap_points  = (c == 2) ? CAP0_6'(2) : CAP0_6'(6);
         adc_datv = 1'b1;
         set_ch(c);
         tick();
         if (m_phase == M_IDLE) break;
      end
      Gc_cap_trig = 1'b0;
      adc_datv = 1'b0;
      chk("busy_trig_words", 64'(got.size()), 64'(6));
      tick();

      // Reset mid-capture discards buffered words
      cap_points = CAP0_6'(10);
      Gc_cap_trig = 1'b1;
      gc_if.Gc_mereg_datr = 1'b0;
      tick();
      Gc_cap_trig = 1'b0;
      for (int c = 0; c < 5; c++) begin
         adc_datv = 1'b1;
         set_ch(c);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      adc_datv = 1'b0;
      chk("midrst_datv", 64'(gc_if.Gc_mereg_datv), 64'(0));
      chk("midrst_rdy", 64'(Gc_capr_rdy), 64'(1));
      run_capture(2, 0);
      chk("postrst_words", 64'(got.size()), 64'(2));
      for (int i = 0; i < got.size() && i < 2; i++)
         chk("postrst_word", 64'(got[i]), 64'(exp_word(i)));
      tick();

      // Randomized traffic, including stray triggers while busy
      for (int r = 0; r < 12; r++) begin
         cap_points = CAP0_6'($urandom_range(0, 40));
         Gc_cap_trig = 1'b1;
         adc_datv = 1'b0;
         tick();
         for (int c = 0; c < 600; c++) begin
            Gc_cap_trig = ($urandom_range(0, 9) == 0);
            cap_points  = CAP0_6'($urandom_range(0, 40));
            adc_datv    = ($urandom_range(0, 9) < 7);
            adc_ch0 = 14'($urandom);
            adc_ch1 = 14'($urandom);
            adc_ch2 = 14'($urandom);
            adc_ch3 = 14'($urandom);
            gc_if.Gc_mereg_datr = ($urandom_range(0, 1) == 1);
            if (m_phase == M_IDLE) Gc_cap_trig = 1'b0;
            tick();
            if (m_phase == M_IDLE) break;
         end
         Gc_cap_trig = 1'b0;
         adc_datv = 1'b0;
         chk("rand_done", 64'(Gc_capr_rdy), 64'(1));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
